// File: rtl/elastic_rr_arb.sv
// elastic_rr_arb: round-robin merge of num_req_p valid/ready streams into one output stream.
// Define ELASTIC_RR_ARB_OUTREG_EN for a registered 1-cycle output stage; default is combinational.
module elastic_rr_arb #(
  parameter int unsigned width_p   = 8,
  parameter int unsigned num_req_p = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic [num_req_p-1:0]           valid_i,
  input  logic [num_req_p*width_p-1:0]   data_i,
  output logic [num_req_p-1:0]           ready_o,
  output logic                           valid_o,
  output logic [width_p-1:0]             data_o,
  output logic [$clog2(num_req_p)-1:0]   grant_id_o,
  input  logic                           ready_i
);

  localparam int unsigned IdW = $clog2(num_req_p);

  logic [IdW-1:0] ptr_q, ptr_d;
  logic           cand_vld;
  logic [IdW-1:0] cand_id;

  // First valid requester at or after ptr_q, wrapping at num_req_p-1.
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + i) % num_req_p;
      if (!cand_vld && valid_i[IdW'(idx)]) begin
        cand_vld = 1'b1;
        cand_id  = IdW'(idx);
      end
    end
  end

  function automatic logic [IdW-1:0] next_ptr(input logic [IdW-1:0] id);
    return (32'(id) == num_req_p - 1) ? '0 : id + 1'b1;
  endfunction

`ifdef ELASTIC_RR_ARB_OUTREG_EN

  logic                 valid_q, valid_d;
  logic [IdW-1:0]       id_q, id_d;
  logic [width_p-1:0]   data_q, data_d;
  logic                 stage_ready;
  logic                 load;

  always_comb begin
    stage_ready = ~valid_q | ready_i;
    // Gated by reset so nothing is accepted while the stage is held clear.
    load        = reset_ni & cand_vld & stage_ready;
    ready_o     = '0;
    if (load) ready_o[cand_id] = 1'b1;
    valid_d     = load | ~stage_ready;
    id_d        = load ? cand_id : id_q;
    data_d      = load ? data_i[32'(cand_id)*width_p +: width_p] : data_q;
    ptr_d       = load ? next_ptr(cand_id) : ptr_q;
    valid_o     = valid_q;
    grant_id_o  = id_q;
    data_o      = data_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

`else

  logic           lock_q, lock_d;
  logic [IdW-1:0] lock_id_q, lock_id_d;
  logic           gnt_vld;
  logic [IdW-1:0] gnt_id;
  logic           xfer;

  always_comb begin
    // A stalled offer stays pinned to its requester until it transfers.
    gnt_vld    = lock_q | cand_vld;
    gnt_id     = lock_q ? lock_id_q : cand_id;
    valid_o    = reset_ni & gnt_vld;
    grant_id_o = reset_ni ? gnt_id : '0;
    data_o     = data_i[32'(gnt_id)*width_p +: width_p];
    xfer       = valid_o & ready_i;
    ready_o    = '0;
    if (xfer) ready_o[gnt_id] = 1'b1;
    lock_d     = gnt_vld & ~ready_i;
    lock_id_d  = gnt_id;
    ptr_d      = xfer ? next_ptr(gnt_id) : ptr_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

`endif

endmodule

// File: tb/tb_elastic_rr_arb.sv
// Randomized self-checking bench for elastic_rr_arb against a behavioural round-robin model
// with per-requester scoreboards; follows ELASTIC_RR_ARB_OUTREG_EN like the design.
module tb_elastic_rr_arb;
  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           clk_i = 1'b0;
  logic           reset_ni;
  logic [N-1:0]   valid_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ready_o;
  logic           valid_o;
  logic [W-1:0]   data_o;
  logic [1:0]     grant_id_o;
  logic           ready_i;

  int checks = 0;
  int errors = 0;

  elastic_rr_arb #(.width_p(W), .num_req_p(N)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .grant_id_o (grant_id_o),
    .ready_i    (ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Requester side: one pending item per requester, plus every item not yet seen at the output.
  bit           req_v   [N];
  logic [W-1:0] req_d   [N];
  logic [W-1:0] exp_q   [N][$];
  int           wait_cnt[N];
  logic [N-1:0] xfer_mask;
  int           grant_log[$];

  // Arbiter model: pointer plus either an output slot or a stall lock.
  int m_ptr;
`ifdef ELASTIC_RR_ARB_OUTREG_EN
  bit           slot_v;
  int           slot_id;
  logic [W-1:0] slot_d;
`else
  bit m_lock;
  int m_lock_id;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
`ifdef ELASTIC_RR_ARB_OUTREG_EN
    slot_v = 0; slot_id = 0; slot_d = '0;
`else
    m_lock = 0; m_lock_id = 0;
`endif
  endtask

  function automatic int find_cand();
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (req_v[k]) return k;
    end
    return -1;
  endfunction

  // Runs at the falling edge: compare outputs, score output transfers, advance the model.
  task automatic eval_cycle(input bit log_en);
    int           c;
    logic [N-1:0] er;
    int           id;
    c  = find_cand();
    er = '0;
    id = -1;
`ifdef ELASTIC_RR_ARB_OUTREG_EN
    begin
      bit sr;
      sr = !slot_v || ready_i;
      check_eq("valid_o", valid_o, slot_v);
      if (slot_v) begin
        check_eq("grant_id_o", grant_id_o, slot_id);
        check_eq("data_o", data_o, slot_d);
      end
      if (c >= 0 && sr) begin
        er[c] = 1'b1;
        id = c;
      end
      if (id >= 0) begin
        slot_v = 1; slot_id = id; slot_d = req_d[id];
      end else if (sr) begin
        slot_v = 0;
      end
    end
`else
    begin
      int g;
      bit ev;
      g  = m_lock ? m_lock_id : c;
      ev = m_lock || (c >= 0);
      check_eq("valid_o", valid_o, ev);
      if (ev) begin
        check_eq("grant_id_o", grant_id_o, g);
        check_eq("data_o", data_o, req_d[g]);
      end
      if (ev && ready_i) begin
        er[g] = 1'b1;
        id = g;
        m_lock = 0;
      end else if (ev) begin
        m_lock = 1; m_lock_id = g;
      end
    end
`endif
    check_eq("ready_o", ready_o, er);
    if (id >= 0) m_ptr = (id + 1) % N;

    if (valid_o && ready_i) begin
      if (log_en) grant_log.push_back(int'(grant_id_o));
      check_eq("sb_pending", exp_q[grant_id_o].size() > 0, 1);
      if (exp_q[grant_id_o].size() > 0) check_eq("sb_data", data_o, exp_q[grant_id_o].pop_front());
    end

    // Wait bound measured on the transfers the design actually accepted.
    xfer_mask = ready_o & valid_i;
    for (int k = 0; k < N; k++) begin
      if (xfer_mask[k]) check_eq("wait_bound", wait_cnt[k] <= N - 1, 1);
      else if (req_v[k] && xfer_mask != '0) wait_cnt[k]++;
    end
  endtask

  task automatic drive(input logic [N-1:0] mask, input int rdy_pct, input int raise_pct);
    for (int k = 0; k < N; k++) begin
      if (!req_v[k] && mask[k] && int'($urandom_range(99)) < raise_pct) begin
        req_v[k]    = 1;
        req_d[k]    = W'($urandom);
        wait_cnt[k] = 0;
        exp_q[k].push_back(req_d[k]);
      end
      valid_i[k]         = req_v[k];
      data_i[k*W +: W]   = req_d[k];
    end
    ready_i = int'($urandom_range(99)) < rdy_pct;
  endtask

  task automatic run_phase(input logic [N-1:0] mask, input int cycles, input int rdy_pct,
                           input int raise_pct, input bit log_en);
    for (int n = 0; n < cycles; n++) begin
      drive(mask, rdy_pct, raise_pct);
      @(negedge clk_i);
      eval_cycle(log_en);
      @(posedge clk_i);
      #1;
      for (int k = 0; k < N; k++) if (xfer_mask[k]) req_v[k] = 0;
    end
  endtask

  // Asserted away from any edge; outputs must clear without a clock.
  task automatic reset_pulse();
    #2 reset_ni = 1'b0;
    #1;
    check_eq("rst_valid_o", valid_o, 0);
    check_eq("rst_ready_o", ready_o, 0);
    check_eq("rst_grant_id_o", grant_id_o, 0);
    for (int k = 0; k < N; k++) begin
      req_v[k] = 0;
      wait_cnt[k] = 0;
      exp_q[k].delete();
    end
    valid_i = '0;
    model_reset();
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int pending;
    int exp_bp[4];
    reset_ni = 1'b0;
    ready_i  = 1'b0;
    valid_i  = '0;
    data_i   = '0;
    for (int k = 0; k < N; k++) begin
      req_v[k] = 0; req_d[k] = '0; wait_cnt[k] = 0;
    end
    model_reset();
    #1;
    check_eq("init_valid_o", valid_o, 0);
    check_eq("init_ready_o", ready_o, 0);
    #10 reset_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // All requesters held valid, downstream always ready.
    run_phase(4'hF, 12, 100, 100, 1);
    for (int i = 0; i < 8; i++)
      check_eq("fair_seq", (i < grant_log.size()) ? grant_log[i] : -1, i % N);

    // Reset with the output occupied, then only requester 3 asks.
    reset_pulse();
    grant_log.delete();
    run_phase(4'h8, 4, 100, 100, 1);
    check_eq("late_first_gid", (grant_log.size() > 0) ? grant_log[0] : -1, 3);

    // Stall five cycles with requesters 1 and 2, then release.
    reset_pulse();
    grant_log.delete();
    run_phase(4'h6, 5, 0, 100, 0);
    run_phase(4'h6, 8, 100, 100, 1);
    exp_bp = '{1, 2, 1, 2};
    for (int i = 0; i < 4; i++)
      check_eq("bp_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_bp[i]);
    run_phase(4'h0, 6, 100, 0, 0);

    // Lone requester 2 streaming.
    run_phase(4'h4, 10, 100, 100, 0);
    run_phase(4'h0, 6, 100, 0, 0);

    // Random traffic.
    run_phase(4'hF, 4000, 60, 40, 0);
    run_phase(4'hF, 4000, 90, 85, 0);
    run_phase(4'h5, 1000, 30, 50, 0);
    run_phase(4'hF, 1000, 20, 90, 0);
    run_phase(4'h0, 30, 100, 0, 0);

    pending = 0;
    for (int k = 0; k < N; k++) pending += exp_q[k].size();
    check_eq("sb_drained", pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elastic_rr_arb.md
ELASTIC_RR_ARB -- requirements
Module: elastic_rr_arb

Interface
REQ-001 Parameter width_p, default 8, payload width per requester (>=1).
REQ-002 Parameter num_req_p, default 4, number of requesters (2..8); id_w = $clog2(num_req_p).
REQ-003 clk_i  input  1  single clock; all state updates on posedge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 valid_i  input  num_req_p  per-requester valid; bit k belongs to requester k.
REQ-006 data_i  input  num_req_p*width_p  requester k payload in bits [k*width_p +: width_p].
REQ-007 ready_o  output  num_req_p  per-requester ready; at most one bit high per cycle (one-hot or zero).
REQ-008 valid_o  output  1  merged output valid.
REQ-009 data_o  output  width_p  merged output payload.
REQ-010 grant_id_o  output  id_w  index of the requester whose payload is on data_o; meaningful only while valid_o=1.
REQ-011 ready_i  input  1  downstream ready.

Function
REQ-012 Transfer on a port occurs in a cycle where valid and ready are both 1; requesters hold valid and data stable until transferred, and the block relies on this.
REQ-013 Arbitration is round-robin: search starts at pointer ptr and wraps from num_req_p-1 to 0; the first k with valid_i[k]=1 is the candidate.
REQ-014 ptr resets to 0; after an input transfer from requester k, ptr <= (k+1) mod num_req_p (wrap at num_req_p-1 -> 0); no transfer -> ptr unchanged.
REQ-015 No valid_i bit set -> no ready_o bit set, no state change other than as required by output drain.
REQ-016 Single requester continuously valid -> granted every transfer opportunity (no bubble inserted by arbitration).
REQ-017 All requesters continuously valid with ready_i=1 -> grants cycle 0,1,...,num_req_p-1,0,... ; max wait for any valid requester is num_req_p-1 transfers.
REQ-018 Valid requests never withdrawn before transfer; a request arriving at a lower-priority index than current candidate never preempts an offered, unaccepted grant (see REQ-021/REQ-024).
REQ-019 grant_id_o and data_o always correspond to the same requester.

Reset
REQ-020 While reset_ni=0 (asynchronously, including mid-transfer): valid_o=0, ready_o=0, ptr=0, grant lock cleared, grant_id_o=0; any in-flight item is dropped; data_o value is don't-care (registered data is not reset).

Configuration
REQ-021 Macro ELASTIC_RR_ARB_OUTREG_EN selects output structure.
REQ-022 Defined: output is one elastic register stage; latency 1 cycle; stage_ready = ~valid_o | ready_i; ready_o[k] = (candidate==k) & stage_ready; on transfer the register loads data, id, valid=1; when stage_ready and no candidate, valid_o <= 0; simultaneous drain and load in the same cycle sustains full throughput (1 item/cycle).
REQ-023 Not defined: combinational path, latency 0; valid_o = (candidate exists); data_o/grant_id_o = candidate's; ready_o[k] = (granted==k) & ready_i; ready_i never combinationally affects the grant choice.
REQ-024 Not defined: if valid_o=1 and ready_i=0, grant is locked to that requester until it transfers; lock clears on transfer or reset; while locked, newly valid requesters are not offered.
REQ-025 Either configuration: no loss, duplication or reordering per requester; output stream order equals grant order.

Verification
REQ-026 Reset: assert reset_ni=0 mid-stream with output full -> valid_o=0, ready_o=0 immediately (no clock edge); after release with valid_i=4'b1000, first grant_id_o=3.
REQ-027 Fairness: num_req_p=4, valid_i=4'b1111 held, ready_i=1, data_i per requester = 8'hA0+k incrementing per transfer -> grant_id_o sequence 0,1,2,3,0,1,... and data_o A0,A1,A2,A3 then next values; OUTREG_EN defined: first valid_o one cycle after first ready_o.
REQ-028 Backpressure: valid_i=4'b0110, ready_i=0 for 5 cycles, then 1 -> no transfers while stalled (OUTREG_EN: exactly one item captured, then ready_o=0), grant_id_o stable at 1, then order 1,2,1,2; no loss/duplication.
REQ-029 Wrap/late arrival: ptr=3 after transfer from 2, valid_i=4'b0001 -> grant 0; with lock held on 1 (no OUTREG_EN), raise valid_i[0] -> grant stays 1 until transfer, then 2 (if valid) else 0.
REQ-030 Single requester: valid_i=4'b0100 held, ready_i=1 -> ready_o[2]=1 every cycle, one item per cycle, grant_id_o=2 throughout.
REQ-031 Random: random valid/data/ready over 10k cycles, both macro settings, scoreboard per requester -> zero mismatches, per-requester wait bound REQ-017 holds.
